mem_arbiter: RTL and testbench

Two-port arbiter and sequencer sitting in front of `Mem_Subsystem`. It shares that single LOAD/STORE memory interface between two requesters (port 0: fetch, port 1: data) using round-robin arbitration. It drives the memory's `LOAD`/`STORE` level protocol, detects completion, and returns a one-cycle `done` pulse with read data to the winning requester.

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/rr_arb2.sv | 23 ++
 rtl/mem_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared definitions for the two-port memory arbiter:
//   - FSM state encodings and the state_t enum built from them
//   - default LOAD_LATENCY / TIMEOUT_CYCLES values
//   - requester index constants (PORT_FETCH, PORT_DATA)
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE_ENC    = 2'd0;
  localparam logic [1:0] ST_LD_WAIT_ENC = 2'd1;
  localparam logic [1:0] ST_ST_WAIT_ENC = 2'd2;
  localparam logic [1:0] ST_DONE_ENC    = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE_ENC,
    S_LD_WAIT = ST_LD_WAIT_ENC,
    S_ST_WAIT = ST_ST_WAIT_ENC,
    S_DONE    = ST_DONE_ENC
  } state_t;

  localparam int DEF_LOAD_LATENCY   = 25;
  localparam int DEF_TIMEOUT_CYCLES = 64;

  localparam int PORT_FETCH = 0;
  localparam int PORT_DATA  = 1;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
//   Combinational two-way round-robin pick.
//   Ports:
//     req  [1:0] in  - request vector (bit N = port N)
//     last       in  - index of the port served most recently
//     win  [1:0] out - one-hot winner, all-zero when nothing requests
//   On a tie the port that was not served last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win
);

  always_comb begin
    win = 2'b00;
    if (req == 2'b11) begin
      win = last ? 2'b01 : 2'b10;
    end else begin
      win = req;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one LOAD/STORE level-protocol memory between a fetch requester
//   (port 0) and a data requester (port 1) with round-robin arbitration.
//   Optional store watchdog: define MEM_ARB_TIMEOUT_EN.
//   Ports:
//     CLK, RST                 clock, synchronous active-high reset
//     reqN, weN, addrN, wdataN requester N: request, store/load, address, data
//     gntN, doneN, rdataN      requester N: grant pulse, completion pulse, load data
//     mem_address, mem_input_data, mem_LOAD, mem_STORE  to memory
//     mem_data, mem_store_completed                     from memory (toggle event)
//     busy                     state is not IDLE
//     err                      sticky store-timeout flag (0 when watchdog absent)
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LOAD_LATENCY   = DEF_LOAD_LATENCY,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_input_data,
  output logic              mem_LOAD,
  output logic              mem_STORE,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_store_completed,
  output logic              busy,
  output logic              err
);

  localparam int CNT_LIM   = (LOAD_LATENCY > TIMEOUT_CYCLES) ? LOAD_LATENCY : TIMEOUT_CYCLES;
  localparam int CNT_W     = $clog2(CNT_LIM + 1);
  localparam int LD_LAST_I = LOAD_LATENCY - 1;
  localparam logic [CNT_W-1:0] LD_LAST = LD_LAST_I[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TO_LAST_I = TIMEOUT_CYCLES - 1;
  localparam logic [CNT_W-1:0] TO_LAST = TO_LAST_I[CNT_W-1:0];
`endif

  state_t           state, state_nx;
  logic [1:0]       req_idle;
  logic [1:0]       win;
  logic             we_sel;
  logic             last_q;   // port served most recently
  logic             port_q;   // port owning the current transaction
  logic             sc_ref;   // store_completed level at launch
  logic [CNT_W-1:0] cnt;
  logic             launch;
  logic             ld_fin;
  logic             cnt_en;
`ifdef MEM_ARB_TIMEOUT_EN
  logic             to_fin;
  logic             err_q;
`endif

  // Requests only count while idle; anything else is ignored.
  assign req_idle = (state == S_IDLE) ? {req1, req0} : 2'b00;

  rr_arb2 u_rr_arb2 (
    .req  (req_idle),
    .last (last_q),
    .win  (win)
  );

  assign we_sel = win[PORT_DATA] ? we1 : we0;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    launch   = 1'b0;
    ld_fin   = 1'b0;
    cnt_en   = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    to_fin   = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (|win) begin
          launch   = 1'b1;
          state_nx = we_sel ? S_ST_WAIT : S_LD_WAIT;
        end
      end
      S_LD_WAIT: begin
        cnt_en = 1'b1;
        if (cnt == LD_LAST) begin
          ld_fin   = 1'b1;
          state_nx = S_DONE;
        end
      end
      S_ST_WAIT: begin
        // Completion is a toggle: any difference from the launch level.
        if (mem_store_completed != sc_ref) begin
          state_nx = S_DONE;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else begin
          cnt_en = 1'b1;
          if (cnt == TO_LAST) begin
            to_fin   = 1'b1;
            state_nx = S_DONE;
          end
        end
`endif
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  assign mem_LOAD  = (state == S_LD_WAIT);
  assign mem_STORE = (state == S_ST_WAIT);
  assign busy      = (state != S_IDLE);
  assign done0     = (state == S_DONE) && !port_q;
  assign done1     = (state == S_DONE) &&  port_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      last_q         <= 1'b1;
      port_q         <= 1'b0;
      sc_ref         <= 1'b0;
      cnt            <= '0;
      gnt0           <= 1'b0;
      gnt1           <= 1'b0;
      mem_address    <= '0;
      mem_input_data <= '0;
      rdata0         <= '0;
      rdata1         <= '0;
    end else begin
      gnt0 <= launch & win[PORT_FETCH];
      gnt1 <= launch & win[PORT_DATA];
      if (launch) begin
        port_q         <= win[PORT_DATA];
        sc_ref         <= mem_store_completed;
        cnt            <= '0;
        mem_address    <= win[PORT_DATA] ? addr1  : addr0;
        mem_input_data <= win[PORT_DATA] ? wdata1 : wdata0;
      end else if (cnt_en && (cnt != CNT_MAX)) begin
        cnt <= cnt + 1'b1;
      end
      if (ld_fin) begin
        if (port_q) begin
          rdata1 <= mem_data;
        end else begin
          rdata0 <= mem_data;
        end
      end
      if (state == S_DONE) begin
        last_q <= port_q;
      end
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      err_q <= 1'b0;
    end else if (to_fin) begin
      err_q <= 1'b1;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter with a behavioural memory model
//   (reads return stored words, initially equal to their address; stores
//   toggle store_completed ST_DELAY cycles after STORE rises unless
//   never_toggle is set) and a scoreboard of expected completions.
//   Watchdog branch follows MEM_ARB_TIMEOUT_EN.
module tb_mem_arbiter;

  localparam int L        = 25;
  localparam int TO       = 64;
  localparam int ST_DELAY = 10;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic        gnt0, gnt1, done0, done1, mem_LOAD, mem_STORE, busy, err;
  logic [31:0] rdata0, rdata1, mem_address, mem_input_data, mem_data;
  logic        mem_store_completed = 1'b0;
  logic        never_toggle = 1'b0;
  int          st_cnt = 0;
  logic [31:0] mem_model [0:255];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          port;
    logic        ld;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  mem_arbiter dut (
    .CLK                 (CLK),
    .RST                 (RST),
    .req0                (req0),
    .req1                (req1),
    .we0                 (we0),
    .we1                 (we1),
    .addr0               (addr0),
    .addr1               (addr1),
    .wdata0              (wdata0),
    .wdata1              (wdata1),
    .gnt0                (gnt0),
    .gnt1                (gnt1),
    .done0               (done0),
    .done1               (done1),
    .rdata0              (rdata0),
    .rdata1              (rdata1),
    .mem_address         (mem_address),
    .mem_input_data      (mem_input_data),
    .mem_LOAD            (mem_LOAD),
    .mem_STORE           (mem_STORE),
    .mem_data            (mem_data),
    .mem_store_completed (mem_store_completed),
    .busy                (busy),
    .err                 (err)
  );

  always #5 CLK = ~CLK;

  // Memory model
  assign mem_data = mem_model[mem_address[7:0]];

  always @(posedge CLK) begin
    if (RST || !mem_STORE) begin
      st_cnt <= 0;
    end else begin
      st_cnt <= st_cnt + 1;
      if (!never_toggle && st_cnt == ST_DELAY - 1) begin
        mem_store_completed <= ~mem_store_completed;
        mem_model[mem_address[7:0]] <= mem_input_data;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest expectation.
  always @(negedge CLK) begin
    if (done0 === 1'b1 || done1 === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", {30'b0, done1, done0}, 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_port", {30'b0, done1, done0}, (e.port == 1) ? 32'h2 : 32'h1);
        if (e.ld) begin
          chk("done_rdata", (e.port == 1) ? rdata1 : rdata0, e.data);
        end
      end
    end
  end

  task automatic launch(input int port, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic push);
    exp_t e;
    if (port == 1) begin
      req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata;
    end else begin
      req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata;
    end
    e.port = port;
    e.ld   = !we;
    e.data = mem_model[addr[7:0]];
    if (push) sb.push_back(e);
  endtask

  task automatic finish_txn(input int port);
    int n;
    n = 0;
    @(negedge CLK);
    while (((port == 1) ? gnt1 : gnt0) !== 1'b1 && n < 4) begin
      n++;
      @(negedge CLK);
    end
    chk("txn_gnt", (port == 1) ? gnt1 : gnt0, 32'h1);
    req0 = 1'b0;
    req1 = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 300) begin
      n++;
      @(negedge CLK);
    end
    chk("txn_idle", busy, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    int bad;
    int ng;
    int gcyc[4];
    int gport[4];

    for (int i = 0; i < 256; i++) mem_model[i] = i;

    // Reset state
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    chk("rst_busy", busy, 32'h0);
    chk("rst_load", mem_LOAD, 32'h0);
    chk("rst_store", mem_STORE, 32'h0);
    chk("rst_gnt", {gnt1, gnt0}, 32'h0);
    chk("rst_done", {done1, done0}, 32'h0);
    chk("rst_err", err, 32'h0);
    chk("rst_rdata0", rdata0, 32'h0);
    chk("rst_addr", mem_address, 32'h0);
    RST = 1'b0;
    @(negedge CLK);

    // Single load on port 0
    launch(0, 1'b0, 32'h20, 32'h0, 1'b1);
    @(negedge CLK);
    chk("ld_gnt0", gnt0, 32'h1);
    chk("ld_gnt1", gnt1, 32'h0);
    chk("ld_busy", busy, 32'h1);
    chk("ld_addr", mem_address, 32'h20);
    req0 = 1'b0;
    n = 0;
    while (mem_LOAD === 1'b1 && n < 200) begin
      n++;
      @(negedge CLK);
    end
    chk("ld_cycles", n, L);
    chk("ld_done0", done0, 32'h1);
    @(negedge CLK);
    chk("ld_idle", busy, 32'h0);
    chk("ld_rdata_hold", rdata0, 32'h20);

    // Single store on port 1
    launch(1, 1'b1, 32'h20, 32'h20, 1'b1);
    @(negedge CLK);
    chk("st_gnt1", gnt1, 32'h1);
    chk("st_store", mem_STORE, 32'h1);
    req1 = 1'b0;
    n = 0;
    bad = 0;
    while (mem_STORE === 1'b1 && n < 200) begin
      n++;
      if (mem_input_data !== 32'h20) bad++;
      @(negedge CLK);
    end
    chk("st_cycles", n, ST_DELAY + 1);
    chk("st_wdata_stable", bad, 32'h0);
    chk("st_done1", done1, 32'h1);
    @(negedge CLK);
    chk("st_idle", busy, 32'h0);

    // Store 0x5A then load it back
    launch(1, 1'b1, 32'h20, 32'h5A, 1'b1);
    finish_txn(1);
    launch(0, 1'b0, 32'h20, 32'h0, 1'b1);
    finish_txn(0);
    chk("st_ld_rdata", rdata0, 32'h5A);

    // Both requesters held from reset: order 0,1,0,1
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    launch(0, 1'b0, 32'h10, 32'h0, 1'b1);
    launch(1, 1'b0, 32'h11, 32'h0, 1'b1);
    launch(0, 1'b0, 32'h10, 32'h0, 1'b1);
    launch(1, 1'b0, 32'h11, 32'h0, 1'b1);
    ng = 0;
    for (int c = 0; c < 400 && ng < 4; c++) begin
      @(negedge CLK);
      if (gnt0 === 1'b1 || gnt1 === 1'b1) begin
        gcyc[ng]  = c;
        gport[ng] = (gnt1 === 1'b1) ? 1 : 0;
        ng++;
        if (ng == 4) begin
          req0 = 1'b0;
          req1 = 1'b0;
        end
      end
    end
    chk("rr_grants", ng, 32'd4);
    for (int i = 0; i < ng; i++) chk("rr_order", gport[i], i % 2);
    for (int i = 1; i < ng; i++) chk("rr_gap", gcyc[i] - gcyc[i-1], L + 2);
    n = 0;
    while (busy === 1'b1 && n < 300) begin
      n++;
      @(negedge CLK);
    end
    chk("rr_idle", busy, 32'h0);

    // Reset in the 10th LD_WAIT cycle drops the load
    launch(0, 1'b0, 32'h30, 32'h0, 1'b1);
    @(negedge CLK);
    chk("mid_gnt", gnt0, 32'h1);
    req0 = 1'b0;
    repeat (9) @(negedge CLK);
    chk("mid_pre_load", mem_LOAD, 32'h1);
    RST = 1'b1;
    sb.delete();
    @(negedge CLK);
    chk("mid_load", mem_LOAD, 32'h0);
    chk("mid_busy", busy, 32'h0);
    chk("mid_done", {done1, done0}, 32'h0);
    chk("mid_rdata0", rdata0, 32'h0);
    chk("mid_addr", mem_address, 32'h0);
    RST = 1'b0;
    @(negedge CLK);
    chk("mid_no_done", {done1, done0}, 32'h0);
    launch(0, 1'b0, 32'h31, 32'h0, 1'b1);
    finish_txn(0);
    chk("mid_after_rdata", rdata0, 32'h31);

    // Store that never completes
    never_toggle = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
    launch(1, 1'b1, 32'h40, 32'h77, 1'b1);
    @(negedge CLK);
    chk("to_gnt", gnt1, 32'h1);
    req1 = 1'b0;
    n = 0;
    while (mem_STORE === 1'b1 && n < 300) begin
      n++;
      @(negedge CLK);
    end
    chk("to_cycles", n, TO);
    chk("to_done1", done1, 32'h1);
    @(negedge CLK);
    chk("to_err", err, 32'h1);
    chk("to_idle", busy, 32'h0);
    never_toggle = 1'b0;
    launch(0, 1'b0, 32'h41, 32'h0, 1'b1);
    finish_txn(0);
    chk("to_err_sticky", err, 32'h1);
    RST = 1'b1;
    @(negedge CLK);
    chk("to_err_rst", err, 32'h0);
    RST = 1'b0;
`else
    launch(1, 1'b1, 32'h40, 32'h77, 1'b0);
    @(negedge CLK);
    chk("hang_gnt", gnt1, 32'h1);
    req1 = 1'b0;
    repeat (100) @(negedge CLK);
    chk("hang_busy", busy, 32'h1);
    chk("hang_store", mem_STORE, 32'h1);
    chk("hang_err", err, 32'h0);
    RST = 1'b1;
    @(negedge CLK);
    chk("hang_rst_busy", busy, 32'h0);
    chk("hang_rst_store", mem_STORE, 32'h0);
    RST = 1'b0;
    never_toggle = 1'b0;
`endif

    @(negedge CLK);
    chk("sb_empty", sb.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
